// File: rtl/run_ctrl_pkg.sv
// Shared types and default widths for the run controller.
// Widths match the 9-bit-instruction processor and its 10-bit PC.
package run_ctrl_pkg;

  localparam int unsigned InstrWidth = 9;
  localparam int unsigned AddrWidth  = 10;
  localparam int unsigned CountWidth = 16;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StStart,
    StRun,
    StDone
  } state_e;

endpackage

// File: rtl/run_cycle_ctr.sv
// Saturating up-counter with synchronous clear and enable.
// Stops incrementing once the count equals max_val.
module run_cycle_ctr #(
  parameter int unsigned W = 16
) (
  input  logic         CLK,
  input  logic         reset_n,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] max_val,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en && (count_q != max_val)) begin
      count_d = count_q + W'(1);
    end
  end

  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/run_ctrl.sv
// Host-side run controller: streams a program into instruction memory, releases the
// processor and counts run cycles until halt. Optional RUN_TIMEOUT_EN adds a run-cycle limit.
module run_ctrl
  import run_ctrl_pkg::*;
#(
  parameter int unsigned    IW           = InstrWidth,
  parameter int unsigned    AW           = AddrWidth,
  parameter int unsigned    CW           = CountWidth,
  parameter int unsigned    START_CYCLES = 2,
  parameter logic [CW-1:0]  MAX_CYCLES   = {CW{1'b1}}
) (
  input  logic          CLK,
  input  logic          reset_n,
  input  logic          load_valid,
  output logic          load_ready,
  input  logic [IW-1:0] load_data,
  input  logic          load_last,
  input  logic          go,
  output logic          imem_we,
  output logic [AW-1:0] imem_addr,
  output logic [IW-1:0] imem_wdata,
  output logic          dut_start,
  input  logic          dut_halt,
  output logic          busy,
  output logic          done,
  output logic [CW-1:0] cycle_count,
  output logic          load_err
`ifdef RUN_TIMEOUT_EN
  ,
  output logic          timeout
`endif
);

`ifdef RUN_TIMEOUT_EN
  localparam logic TimeoutEn = 1'b1;
`else
  localparam logic TimeoutEn = 1'b0;
`endif
  localparam logic [CW-1:0] HoldMax = CW'(START_CYCLES - 1);

  state_e        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          load_err_q, load_err_d;
  logic          load_ready_q, load_ready_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          dut_start_q, dut_start_d;
  logic          beat, idle_like, timeout_hit;
  logic [CW-1:0] hold_cnt, cyc_max;

  assign beat        = load_valid & load_ready_q;
  assign idle_like   = (state_q == StIdle) || (state_q == StDone);
  assign timeout_hit = TimeoutEn && (state_q == StRun) && !dut_halt &&
                       (cycle_count == MAX_CYCLES);
  // Without the timeout option the run counter simply saturates at all-ones.
  assign cyc_max     = TimeoutEn ? MAX_CYCLES : {CW{1'b1}};

  run_cycle_ctr #(.W(CW)) u_hold_ctr (
    .CLK     (CLK),
    .reset_n (reset_n),
    .clr     (state_q != StStart),
    .en      (state_q == StStart),
    .max_val (HoldMax),
    .count   (hold_cnt)
  );

  run_cycle_ctr #(.W(CW)) u_run_ctr (
    .CLK     (CLK),
    .reset_n (reset_n),
    .clr     ((beat && idle_like) || ((state_q == StStart) && (state_d == StRun))),
    .en      ((state_q == StRun) && !dut_halt),
    .max_val (cyc_max),
    .count   (cycle_count)
  );

  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle, StDone: begin
        if (beat) begin
          state_d = load_last ? StStart : StLoad;
        end else if (go) begin
          state_d = StStart;
        end
      end
      StLoad:  if (beat && load_last) state_d = StStart;
      StStart: if (hold_cnt == HoldMax) state_d = StRun;
      StRun:   if (dut_halt || timeout_hit) state_d = StDone;
      default: state_d = StIdle;
    endcase
  end

  // addr returns to 0 after the last beat so IDLE/DONE always write word 0 first.
  always_comb begin
    imem_we      = beat;
    imem_addr    = addr_q;
    imem_wdata   = load_data;
    addr_d       = addr_q;
    load_err_d   = load_err_q;
    if (beat) begin
      if (idle_like) begin
        load_err_d = 1'b0;
        addr_d     = load_last ? '0 : AW'(1);
      end else begin
        addr_d = load_last ? '0 : addr_q + AW'(1);
        if (!load_last && (addr_q == {AW{1'b1}})) load_err_d = 1'b1;
      end
    end
    load_ready_d = state_d inside {StIdle, StLoad, StDone};
    busy_d       = state_d inside {StLoad, StStart, StRun};
    done_d       = (state_d == StDone);
    dut_start_d  = (state_d != StRun);
  end

  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      addr_q       <= '0;
      load_err_q   <= 1'b0;
      load_ready_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      dut_start_q  <= 1'b1;
    end else begin
      addr_q       <= addr_d;
      load_err_q   <= load_err_d;
      load_ready_q <= load_ready_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      dut_start_q  <= dut_start_d;
    end
  end

  assign load_ready = load_ready_q;
  assign load_err   = load_err_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign dut_start  = dut_start_q;

`ifdef RUN_TIMEOUT_EN
  logic timeout_q;

  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      timeout_q <= 1'b0;
    end else if (timeout_hit) begin
      timeout_q <= 1'b1;
    end else if ((state_q == StDone) && (state_d != StDone)) begin
      timeout_q <= 1'b0;
    end
  end

  assign timeout = timeout_q;
`endif

endmodule
